// File: rtl/ecg_window_ctrl.sv
// ECG peak-window controller: buffers one frame, tracks the two largest samples,
// then streams the frame back with everything outside the peak window zeroed.
// Optional build macro ECG_WINDOW_PEAKVAL_EN adds the peak_max_val/peak_sec_val outputs.
module ecg_window_ctrl #(
  parameter int SIGNAL_LENGTH = 187,
  parameter int DATA_W = 13,
  localparam int IDX_W = $clog2(SIGNAL_LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [IDX_W-1:0]  win_start,
  output logic [IDX_W-1:0]  win_end,
`ifdef ECG_WINDOW_PEAKVAL_EN
  output logic              frame_done,
  output logic [DATA_W-1:0] peak_max_val,
  output logic [DATA_W-1:0] peak_sec_val
`else
  output logic              frame_done
`endif
);

  typedef enum logic [1:0] {LOAD, ORDER, EMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIGNAL_LENGTH - 1);

  generate
    if (SIGNAL_LENGTH < 2) begin : g_len_check
      $error("ecg_window_ctrl: SIGNAL_LENGTH must be >= 2");
    end
  endgenerate

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf [SIGNAL_LENGTH];
  logic [DATA_W-1:0] r_max_val, r_sec_val;
  logic [IDX_W-1:0]  r_max_idx, r_sec_idx;
  logic [IDX_W-1:0]  r_win_start, r_win_end;
  logic              r_in_ready;
  logic              w_in_fire, w_out_fire, w_is_last, w_in_window;

  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_fire  = (r_state == EMIT) && out_ready;
  assign w_is_last   = (r_cnt == LAST_IDX);
  assign w_in_window = (r_cnt >= r_win_start) && (r_cnt <= r_win_end);

  assign in_ready  = r_in_ready;
  assign win_start = r_win_start;
  assign win_end   = r_win_end;

  always_comb begin
    w_state_next = r_state;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    frame_done   = 1'b0;
    case (r_state)
      LOAD:  if (w_in_fire && w_is_last) w_state_next = ORDER;
      ORDER: w_state_next = EMIT;
      EMIT: begin
        out_valid  = 1'b1;
        out_last   = w_is_last;
        frame_done = w_out_fire && w_is_last;
        if (w_in_window) out_data = r_buf[r_cnt];
        if (w_out_fire && w_is_last) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
  end

  // in_ready is registered so it stays low in the reset cycle itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_max_val   <= '0;
      r_sec_val   <= '0;
      r_max_idx   <= '0;
      r_sec_idx   <= '0;
      r_win_start <= '0;
      r_win_end   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == LOAD);
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
              r_max_val <= in_data;
              r_max_idx <= '0;
              r_sec_val <= '0;
              r_sec_idx <= '0;
            end else if (r_cnt == IDX_W'(1)) begin
              // Second sample always fills the runner-up slot, even when it is zero.
              if (in_data > r_max_val) begin
                r_max_val <= in_data;
                r_max_idx <= r_cnt;
                r_sec_val <= r_max_val;
                r_sec_idx <= r_max_idx;
              end else begin
                r_sec_val <= in_data;
                r_sec_idx <= r_cnt;
              end
            end else if (in_data > r_max_val) begin
              r_max_val <= in_data;
              r_max_idx <= r_cnt;
              r_sec_val <= r_max_val;
              r_sec_idx <= r_max_idx;
            end else if (in_data > r_sec_val) begin
              r_sec_val <= in_data;
              r_sec_idx <= r_cnt;
            end
          end
        end
        ORDER: begin
          r_cnt       <= '0;
          r_win_start <= (r_max_idx < r_sec_idx) ? r_max_idx : r_sec_idx;
          r_win_end   <= (r_max_idx < r_sec_idx) ? r_sec_idx : r_max_idx;
        end
        EMIT: begin
          if (w_out_fire) r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_cnt] <= in_data;
  end

`ifdef ECG_WINDOW_PEAKVAL_EN
  logic [DATA_W-1:0] r_peak_max, r_peak_sec;

  assign peak_max_val = r_peak_max;
  assign peak_sec_val = r_peak_sec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_peak_max <= '0;
      r_peak_sec <= '0;
    end else if (r_state == ORDER) begin
      r_peak_max <= r_max_val;
      r_peak_sec <= r_sec_val;
    end
  end
`endif

endmodule

// File: tb/tb_ecg_window_ctrl.sv
// Scoreboard bench for ecg_window_ctrl: an 8-sample instance for directed frames
// plus a full-length 187-sample instance for the edge-peak window.
module tb_ecg_window_ctrl;
  localparam int SL  = 8;
  localparam int DW  = 13;
  localparam int IW  = $clog2(SL);
  localparam int BL  = 187;
  localparam int BIW = $clog2(BL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [DW-1:0] in_data, out_data;
  logic [IW-1:0] win_start, win_end;

  logic           b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
  logic [DW-1:0]  b_in_data, b_out_data;
  logic [BIW-1:0] b_win_start, b_win_end;

`ifdef ECG_WINDOW_PEAKVAL_EN
  logic [DW-1:0] peak_max_val, peak_sec_val, b_peak_max_val, b_peak_sec_val;
`endif

  ecg_window_ctrl #(.SIGNAL_LENGTH(SL), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .win_start(win_start), .win_end(win_end),
`ifdef ECG_WINDOW_PEAKVAL_EN
    .frame_done(frame_done), .peak_max_val(peak_max_val), .peak_sec_val(peak_sec_val)
`else
    .frame_done(frame_done)
`endif
  );

  ecg_window_ctrl #(.SIGNAL_LENGTH(BL), .DATA_W(DW)) dutBig (
    .clk(clk), .rst_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .win_start(b_win_start), .win_end(b_win_end),
`ifdef ECG_WINDOW_PEAKVAL_EN
    .frame_done(b_frame_done), .peak_max_val(b_peak_max_val), .peak_sec_val(b_peak_sec_val)
`else
    .frame_done(b_frame_done)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic [DW:0] expQ[$];

  int vecIn  [8][SL];
  int vecOut [8][SL];
  int vecWs  [8];
  int vecWe  [8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every presented output is compared against the head of the expectation queue.
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        if (out_ready) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected handshake: got data %0d, expected no output", out_data);
        end
      end else begin
        exp = expQ[0];
        if (out_ready) checkOutput("out_data", int'(out_data), int'(exp[DW-1:0]));
        else           checkOutput("stall out_data", int'(out_data), int'(exp[DW-1:0]));
        checkOutput("out_last", int'(out_last), int'(exp[DW]));
        checkOutput("in_ready in EMIT", int'(in_ready), 0);
        if (out_ready) begin
          checkOutput("frame_done", int'(frame_done), int'(exp[DW]));
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic pushSample(input int v, input bit gap);
    int guard = 0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = DW'(v);
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    checkOutput("in_ready wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drainFrame(input int stallAt, input int stallLen);
    int seen = 0, guard = 0, stalled = 0;
    bit fin = 1'b0;
    while (!fin && guard < 100) begin
      if (seen == stallAt && stalled < stallLen) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      fin = out_valid && out_ready && out_last;
      if (out_valid && out_ready) seen++;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    checkOutput("frame drained", int'(fin), 1);
    checkOutput("in_ready after frame_done", int'(in_ready), 1);
    checkOutput("out_valid after frame_done", int'(out_valid), 0);
  endtask

  task automatic applyStimulus(input int t, input bit gaps, input int stallAt, input int stallLen);
    logic [DW:0] e;
    for (int i = 0; i < SL; i++) begin
      e = {(i == SL - 1) ? 1'b1 : 1'b0, DW'(vecOut[t][i])};
      expQ.push_back(e);
    end
    for (int i = 0; i < SL; i++) pushSample(vecIn[t][i], gaps);
    checkOutput("ORDER out_valid", int'(out_valid), 0);
    checkOutput("ORDER in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    checkOutput("first out_valid latency", int'(out_valid), 1);
    checkOutput("win_start", int'(win_start), vecWs[t]);
    checkOutput("win_end", int'(win_end), vecWe[t]);
    drainFrame(stallAt, stallLen);
  endtask

  function automatic int bigSample(input int i);
    if (i == BL - 1) return 4000;
    if (i == 0) return 3000;
    return i % 100;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int errs, lastAt, guard;
    vecIn  = '{'{5,1,9,2,7,3,0,4}, '{3,3,1,1,1,1,1,1}, '{2,8,8,0,0,0,0,0}, '{9,0,0,0,0,0,0,9},
               '{7,6,5,4,3,2,1,0}, '{10,20,30,40,50,60,70,80}, '{1,2,3,4,5,6,7,6},
               '{100,8191,50,8190,0,0,0,0}};
    vecOut = '{'{0,0,9,2,7,0,0,0}, '{3,3,0,0,0,0,0,0}, '{0,8,8,0,0,0,0,0}, '{9,0,0,0,0,0,0,9},
               '{7,6,0,0,0,0,0,0}, '{0,0,0,0,0,0,70,80}, '{0,0,0,0,0,6,7,0},
               '{0,8191,50,8190,0,0,0,0}};
    vecWs  = '{2, 0, 1, 0, 0, 6, 5, 1};
    vecWe  = '{4, 1, 2, 7, 1, 7, 6, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    checkOutput("reset win_start", int'(win_start), 0);
    checkOutput("reset win_end", int'(win_end), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
`ifdef ECG_WINDOW_PEAKVAL_EN
    checkOutput("reset peak_max_val", int'(peak_max_val), 0);
    checkOutput("reset peak_sec_val", int'(peak_sec_val), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready after reset", int'(in_ready), 1);

    applyStimulus(0, 1'b0, -1, 0);
`ifdef ECG_WINDOW_PEAKVAL_EN
    checkOutput("peak_max_val", int'(peak_max_val), 9);
    checkOutput("peak_sec_val", int'(peak_sec_val), 7);
`endif
    applyStimulus(1, 1'b0, -1, 0);
    applyStimulus(2, 1'b0, -1, 0);
    applyStimulus(3, 1'b0, -1, 0);
    applyStimulus(4, 1'b0, -1, 0);
    applyStimulus(5, 1'b1, 6, 3);

    // Partial frame followed by a one-cycle reset must not leak into the next frame.
    for (int i = 1; i <= 4; i++) pushSample(i * 100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid-load reset in_ready", int'(in_ready), 0);
    checkOutput("mid-load reset out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(6, 1'b0, -1, 0);

    // Reset while a frame is being presented but not yet consumed.
    for (int i = 0; i < SL; i++) pushSample(vecIn[0][i], 1'b0);
    @(posedge clk); #1;
    checkOutput("pre-reset out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid-emit reset out_valid", int'(out_valid), 0);
    checkOutput("mid-emit reset out_data", int'(out_data), 0);
    checkOutput("mid-emit reset in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready after mid-emit reset", int'(in_ready), 1);
    applyStimulus(7, 1'b1, -1, 0);

    // Full-length frame: max at the last index, runner-up at index 0.
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < BL; i++) begin
      guard = 0;
      b_in_valid = 1'b1;
      b_in_data  = DW'(bigSample(i));
      while (!b_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (!b_in_ready) begin
        checkOutput("big in_ready wait", int'(b_in_ready), 1);
        break;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("big first out_valid", int'(b_out_valid), 1);
    checkOutput("big win_start", int'(b_win_start), 0);
    checkOutput("big win_end", int'(b_win_end), BL - 1);
`ifdef ECG_WINDOW_PEAKVAL_EN
    checkOutput("big peak_max_val", int'(b_peak_max_val), 4000);
    checkOutput("big peak_sec_val", int'(b_peak_sec_val), 3000);
`endif
    errs = 0;
    lastAt = -1;
    b_out_ready = 1'b1;
    for (int i = 0; i < BL; i++) begin
      if (!b_out_valid || int'(b_out_data) != bigSample(i)) errs++;
      if (b_out_last && lastAt < 0) lastAt = i;
      if (b_out_last && !b_frame_done) errs++;
      @(posedge clk); #1;
    end
    b_out_ready = 1'b0;
    checkOutput("big out_data errors", errs, 0);
    checkOutput("big out_last index", lastAt, BL - 1);
    checkOutput("big out_valid after frame", int'(b_out_valid), 0);
    checkOutput("big in_ready after frame", int'(b_in_ready), 1);

    checkOutput("scoreboard left over", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
